// File: rtl/mem_refill_arbiter_if.sv
// mem_refill_arbiter_if: cache-side fill requests/responses and main-memory read port of the refill arbiter
interface mem_refill_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic load0, load1, doneLoading0, doneLoading1, memRead, memReady, busy, grant;
  logic [ADDR_W-1:0] loadIndex0, loadIndex1, memAddr;
  logic [2*DATA_W-1:0] dataFromMain0, dataFromMain1;
  logic [DATA_W-1:0] memData;
  modport slave (
    input load0, loadIndex0, load1, loadIndex1, memData, memReady,
    output dataFromMain0, doneLoading0, dataFromMain1, doneLoading1, memRead, memAddr, busy, grant
  );
  modport master (
    output load0, loadIndex0, load1, loadIndex1, memData, memReady,
    input dataFromMain0, doneLoading0, dataFromMain1, doneLoading1, memRead, memAddr, busy, grant
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin arbiter filling two-word cache lines for two ports from word-wide main memory
module mem_refill_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  mem_refill_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;
  state_t r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_lo, w_lo;
  logic [2*DATA_W-1:0] r_data0, w_data0, r_data1, w_data1;
  logic r_read, w_read, r_done0, w_done0, r_done1, w_done1;
  logic r_grant, w_grant, r_last, w_last, r_busy;
  logic w_rdy, w_win, w_load_g;
  assign w_rdy = bus.memReady & r_read;
  // on contention the port that was not served last wins
  assign w_win = (bus.load0 & bus.load1) ? ~r_last : bus.load1;
  assign w_load_g = r_grant ? bus.load1 : bus.load0;
  always_comb begin
    w_state = r_state;
    w_addr = r_addr;
    w_read = r_read;
    w_lo = r_lo;
    w_data0 = r_data0;
    w_data1 = r_data1;
    w_done0 = r_done0;
    w_done1 = r_done1;
    w_grant = r_grant;
    w_last = r_last;
    case (r_state)
      IDLE: if (bus.load0 || bus.load1) begin
        w_state = RD0;
        w_grant = w_win;
        w_last = w_win;
        w_addr = w_win ? bus.loadIndex1 : bus.loadIndex0;
        w_read = 1'b1;
      end
      RD0: if (w_rdy) begin
        w_lo = bus.memData;
        w_addr = r_addr + ADDR_W'(1);
        w_state = RD1;
      end
      RD1: if (w_rdy) begin
        w_read = 1'b0;
        w_state = DONE;
        w_data0 = r_grant ? r_data0 : {bus.memData, r_lo};
        w_data1 = r_grant ? {bus.memData, r_lo} : r_data1;
        w_done0 = ~r_grant;
        w_done1 = r_grant;
      end
      DONE: if (!w_load_g) begin
        w_state = IDLE;
        w_done0 = 1'b0;
        w_done1 = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_read <= 1'b0;
      r_lo <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_grant <= 1'b0;
      r_last <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_read <= w_read;
      r_lo <= w_lo;
      r_data0 <= w_data0;
      r_data1 <= w_data1;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_grant <= w_grant;
      r_last <= w_last;
      r_busy <= w_state != IDLE;
    end
  end
  assign bus.memAddr = r_addr;
  assign bus.memRead = r_read;
  assign bus.dataFromMain0 = r_data0;
  assign bus.dataFromMain1 = r_data1;
  assign bus.doneLoading0 = r_done0;
  assign bus.doneLoading1 = r_done1;
  assign bus.grant = r_grant;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed and randomized line fills checked against a transaction-level model
module tb_mem_refill_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy = 1'b0;
  logic ld [2];
  logic [3:0] ix [2];
  logic [31:0] mem [16];
  logic [63:0] m_data [2];
  int m_last;
  int tests = 0;
  int fails = 0;
  int r, p;
  mem_refill_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();
  mem_refill_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.load0 = ld[0];
  assign bus.load1 = ld[1];
  assign bus.loadIndex0 = ix[0];
  assign bus.loadIndex1 = ix[1];
  assign bus.memReady = rdy;
  assign bus.memData = mem[bus.memAddr];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic done_of(input int q);
    return (q != 0) ? bus.doneLoading1 : bus.doneLoading0;
  endfunction
  function automatic logic [63:0] data_of(input int q);
    return (q != 0) ? bus.dataFromMain1 : bus.dataFromMain0;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_memRead"}, bus.memRead, 0);
    chk({tag, "_memAddr"}, bus.memAddr, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_done0"}, bus.doneLoading0, 0);
    chk({tag, "_done1"}, bus.doneLoading1, 0);
    chk({tag, "_data0"}, bus.dataFromMain0, 0);
    chk({tag, "_data1"}, bus.dataFromMain1, 0);
    m_data[0] = '0;
    m_data[1] = '0;
    m_last = 1;
  endtask
  // Port p is requesting and the arbiter is idle; memReady stalls s0 cycles on the
  // first word and s1 on the second. drop releases load right after the grant,
  // otherwise load is held for hold cycles after doneLoading rises.
  task automatic serve(input int q, input int s0, input int s1, input bit drop, input int hold);
    logic [3:0] b, b1;
    logic [63:0] e;
    int k;
    b = ix[q];
    b1 = b + 4'd1;
    e = {mem[b1], mem[b]};
    rdy = 1'($urandom);
    tick();
    chk("grant", bus.grant, q);
    chk("busy", bus.busy, 1);
    chk("first_addr", bus.memAddr, b);
    if (drop) ld[q] = 1'b0;
    for (k = 1; k < 40 && !done_of(q); k++) begin
      chk("read_held", bus.memRead, 1);
      chk("addr_held", bus.memAddr, (k <= s0 + 1) ? b : b1);
      rdy = !((k <= s0) || (k >= s0 + 2 && k <= s0 + 1 + s1));
      tick();
    end
    chk("latency", k, 3 + s0 + s1);
    chk("line", data_of(q), e);
    chk("other_line", data_of(1 - q), m_data[1 - q]);
    chk("other_done", done_of(1 - q), 0);
    chk("read_off", bus.memRead, 0);
    m_data[q] = e;
    m_last = q;
    if (!drop) begin
      repeat (hold) begin
        rdy = 1'($urandom);
        tick();
        chk("done_hold", done_of(q), 1);
      end
      ld[q] = 1'b0;
    end
    tick();
    chk("done_fall", done_of(q), 0);
    chk("idle", bus.busy, 0);
    chk("line_keep", data_of(q), e);
  endtask
  initial begin
    ld[0] = 1'b0;
    ld[1] = 1'b0;
    ix[0] = '0;
    ix[1] = '0;
    for (int i = 0; i < 16; i++) mem[i] = i[0] ? 32'hFFFFAAAA : 32'hAAAAFFFF;
    tick();
    tick();
    chk_reset("reset");
    reset = 1'b0;
    ld[0] = 1'b1;
    ix[0] = 4'd2;
    serve(0, 0, 0, 1'b0, 2);
    chk("basic_line", bus.dataFromMain0, 64'hFFFFAAAA_AAAAFFFF);
    reset = 1'b1;
    #1;
    chk_reset("reset2");
    reset = 1'b0;
    ld[0] = 1'b1;
    ld[1] = 1'b1;
    ix[0] = 4'd4;
    ix[1] = 4'd6;
    serve(0, 0, 0, 1'b0, 1);
    serve(1, 0, 0, 1'b0, 0);
    ld[1] = 1'b1;
    ix[1] = 4'd15;
    serve(1, 0, 0, 1'b0, 0);
    chk("wrap_line", bus.dataFromMain1, 64'hAAAAFFFF_FFFFAAAA);
    ld[0] = 1'b1;
    ix[0] = 4'd7;
    serve(0, 3, 2, 1'b0, 1);
    ld[1] = 1'b1;
    ix[1] = 4'd3;
    serve(1, 0, 0, 1'b1, 0);
    ld[0] = 1'b1;
    ix[0] = 4'd9;
    rdy = 1'b1;
    tick();
    tick();
    rdy = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset("midfill_reset");
    reset = 1'b0;
    ld[0] = 1'b0;
    rdy = 1'b1;
    repeat (4) begin
      tick();
      chk("abandon_done", bus.doneLoading0, 0);
      chk("abandon_data", bus.dataFromMain0, 0);
    end
    ld[0] = 1'b1;
    serve(0, 1, 0, 1'b0, 0);
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (30) begin
      r = $urandom_range(1, 3);
      ld[0] = r[0];
      ld[1] = r[1];
      ix[0] = 4'($urandom);
      ix[1] = 4'($urandom);
      while (ld[0] || ld[1]) begin
        p = (ld[0] && ld[1]) ? 1 - m_last : (ld[1] ? 1 : 0);
        serve(p, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) != 0) tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
